e2prom_rw_seq: RTL and testbench

Parametrised EEPROM read/write self-test sequencer. It replaces the fixed-count write/read test in the EEPROM top level. It drives the I2C driver's command interface to write a MAX_BYTE-long pattern from START_ADDR, waits the EEPROM write cycle, reads the bytes back, compares them and reports the result. It adds selectable data patterns, NACK retry, error counting and a LED pass/fail indicator.

---
 rtl/e2prom_rw_seq_pkg.sv | 31 +++
 rtl/e2prom_pat_gen.sv | 38 +++
 rtl/e2prom_rw_seq.sv | 214 +++++++++++++++++++++
 tb/tb_e2prom_rw_seq.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e2prom_rw_seq_pkg.sv
// Shared definitions for the EEPROM read/write self-test sequencer:
// FSM state encodings, data-pattern codes and the pattern LFSR.
package e2prom_rw_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_WR_REQ  = 4'd1,
    ST_WR_WAIT = 4'd2,
    ST_WR_DLY  = 4'd3,
    ST_RD_REQ  = 4'd4,
    ST_RD_WAIT = 4'd5,
    ST_CHECK   = 4'd6,
    ST_DONE    = 4'd7,
    ST_FAIL    = 4'd8
  } state_t;

  localparam logic [1:0] PAT_ADDR  = 2'd0;
  localparam logic [1:0] PAT_INV   = 2'd1;
  localparam logic [1:0] PAT_LFSR  = 2'd2;
  localparam logic [1:0] PAT_CONST = 2'd3;

  localparam logic [7:0] PAT_CONST_BYTE = 8'h55;
  localparam logic [7:0] LFSR_SEED      = 8'hA5;
  // Fibonacci taps for x^8+x^6+x^5+x^4+1 (register bits 7,5,4,3)
  localparam logic [7:0] LFSR_TAPS      = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/e2prom_pat_gen.sv
// Expected-byte generator: address-derived, inverted, LFSR or constant data.
// The LFSR advances on step and is reloaded with the seed on reseed.
module e2prom_pat_gen
  import e2prom_rw_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic [7:0] addr,
  input  logic       step,
  input  logic       reseed,
  output logic [7:0] pat_byte
);

  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (reseed) begin
      lfsr <= LFSR_SEED;
    end else if (step) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  always_comb begin
    pat_byte = addr;
    case (mode)
      PAT_ADDR:  pat_byte = addr;
      PAT_INV:   pat_byte = ~addr;
      PAT_LFSR:  pat_byte = lfsr;
      PAT_CONST: pat_byte = PAT_CONST_BYTE;
      default:   pat_byte = addr;
    endcase
  end

endmodule

// File: rtl/e2prom_rw_seq.sv
// EEPROM write/read-back self-test sequencer driving the I2C command interface.
// Optional build macro E2PROM_RW_STOP_ON_ERR_EN: abort on the first read mismatch.
module e2prom_rw_seq
  import e2prom_rw_seq_pkg::*;
#(
  parameter logic [15:0] MAX_BYTE   = 16'd3,
  parameter logic [15:0] START_ADDR = 16'h0000,
  parameter logic        BIT_CTRL   = 1'b1,
  parameter logic [19:0] WR_WAIT    = 20'd250_000,
  parameter logic [1:0]  PATTERN    = 2'd0,
  parameter logic [2:0]  RETRY_MAX  = 3'd3,
  parameter logic [24:0] L_TIME     = 25'd25_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  output logic        i2c_exec,
  output logic        i2c_rh_wl,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_data_w,
  input  logic [7:0]  i2c_data_r,
  input  logic        i2c_done,
  input  logic        i2c_ack,
  output logic        busy,
  output logic        rw_done,
  output logic        rw_pass,
  output logic [15:0] err_cnt,
  output logic        led
);

  state_t      state;
  logic [15:0] idx;
  logic [2:0]  retry;
  logic [19:0] dly_cnt;
  logic [7:0]  exp_byte;
  logic [7:0]  rd_byte;
  logic [24:0] led_cnt;
  logic        show_pass;
  logic        show_fail;
  logic [15:0] cur_addr;
  logic [7:0]  pat_byte;
  logic        pat_step;
  logic        pat_reseed;
  logic        last_byte;
  logic        dly_end;

  assign last_byte = (idx == MAX_BYTE - 16'd1);
  assign dly_end   = (WR_WAIT == 20'd0) || (dly_cnt >= WR_WAIT - 20'd1);

  // 8-bit addressing wraps inside the low byte and keeps the high byte clear
  always_comb begin
    if (BIT_CTRL) begin
      cur_addr = START_ADDR + idx;
    end else begin
      cur_addr = {8'h00, START_ADDR[7:0] + idx[7:0]};
    end
  end

  assign pat_reseed = ((state == ST_IDLE) && start) ||
                      ((state == ST_WR_DLY) && dly_end && last_byte);
  assign pat_step   = ((state == ST_WR_DLY) && dly_end && !last_byte) ||
                      (state == ST_CHECK);

  e2prom_pat_gen u_pat_gen (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .mode     (PATTERN),
    .addr     (cur_addr[7:0]),
    .step     (pat_step),
    .reseed   (pat_reseed),
    .pat_byte (pat_byte)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      idx        <= 16'd0;
      retry      <= 3'd0;
      dly_cnt    <= 20'd0;
      exp_byte   <= 8'h00;
      rd_byte    <= 8'h00;
      show_pass  <= 1'b0;
      show_fail  <= 1'b0;
      i2c_exec   <= 1'b0;
      i2c_rh_wl  <= 1'b0;
      i2c_addr   <= 16'h0000;
      i2c_data_w <= 8'h00;
      busy       <= 1'b0;
      rw_done    <= 1'b0;
      rw_pass    <= 1'b0;
      err_cnt    <= 16'h0000;
    end else begin
      i2c_exec <= 1'b0;
      rw_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            rw_pass   <= 1'b0;
            err_cnt   <= 16'h0000;
            idx       <= 16'd0;
            retry     <= 3'd0;
            show_pass <= 1'b0;
            show_fail <= 1'b0;
            state     <= ST_WR_REQ;
          end
        end
        ST_WR_REQ: begin
          i2c_exec   <= 1'b1;
          i2c_rh_wl  <= 1'b0;
          i2c_addr   <= cur_addr;
          i2c_data_w <= pat_byte;
          state      <= ST_WR_WAIT;
        end
        ST_WR_WAIT: begin
          if (i2c_done) begin
            if (!i2c_ack) begin
              retry   <= 3'd0;
              dly_cnt <= 20'd0;
              state   <= ST_WR_DLY;
            end else if (retry < RETRY_MAX) begin
              retry <= retry + 3'd1;
              state <= ST_WR_REQ;
            end else begin
              state <= ST_FAIL;
            end
          end
        end
        ST_WR_DLY: begin
          if (dly_end) begin
            if (last_byte) begin
              idx   <= 16'd0;
              state <= ST_RD_REQ;
            end else begin
              idx   <= idx + 16'd1;
              state <= ST_WR_REQ;
            end
          end else begin
            dly_cnt <= dly_cnt + 20'd1;
          end
        end
        ST_RD_REQ: begin
          i2c_exec  <= 1'b1;
          i2c_rh_wl <= 1'b1;
          i2c_addr  <= cur_addr;
          exp_byte  <= pat_byte;
          state     <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (i2c_done) begin
            if (!i2c_ack) begin
              retry   <= 3'd0;
              rd_byte <= i2c_data_r;
              state   <= ST_CHECK;
            end else if (retry < RETRY_MAX) begin
              retry <= retry + 3'd1;
              state <= ST_RD_REQ;
            end else begin
              state <= ST_FAIL;
            end
          end
        end
        ST_CHECK: begin
          idx   <= idx + 16'd1;
          state <= last_byte ? ST_DONE : ST_RD_REQ;
          if (rd_byte != exp_byte) begin
`ifdef E2PROM_RW_STOP_ON_ERR_EN
            err_cnt <= 16'd1;
            state   <= ST_FAIL;
`else
            if (err_cnt != 16'hFFFF) begin
              err_cnt <= err_cnt + 16'd1;
            end
`endif
          end
        end
        ST_DONE: begin
          busy      <= 1'b0;
          rw_done   <= 1'b1;
          rw_pass   <= (err_cnt == 16'h0000);
          show_pass <= (err_cnt == 16'h0000);
          show_fail <= (err_cnt != 16'h0000);
          state     <= ST_IDLE;
        end
        ST_FAIL: begin
          busy      <= 1'b0;
          rw_done   <= 1'b1;
          rw_pass   <= 1'b0;
          show_pass <= 1'b0;
          show_fail <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Result indicator: steady on pass, blinks with half-period L_TIME on failure
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led     <= 1'b0;
      led_cnt <= 25'd0;
    end else if (!show_fail) begin
      led     <= show_pass;
      led_cnt <= 25'd0;
    end else if (led_cnt >= L_TIME - 25'd1) begin
      led     <= ~led;
      led_cnt <= 25'd0;
    end else begin
      led_cnt <= led_cnt + 25'd1;
    end
  end

endmodule

// File: tb/tb_e2prom_rw_seq.sv
// Scoreboard bench for e2prom_rw_seq: two configurations share one EEPROM model;
// expected commands/results are queued by the stimulus and popped by a monitor.
module tb_e2prom_rw_seq;

  typedef struct packed {
    logic        rh;
    logic [15:0] addr;
    logic [7:0]  data;
  } cmd_t;

  typedef struct packed {
    logic        pass;
    logic [15:0] err;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic sel = 1'b0;
  logic done = 1'b0;
  logic ack = 1'b0;
  logic [7:0] rdata = 8'h00;
  logic done_a, done_b;

  logic exec_a, rh_a, busy_a, rwd_a, pass_a, led_a;
  logic [15:0] addr_a, err_a;
  logic [7:0] dw_a;
  logic exec_b, rh_b, busy_b, rwd_b, pass_b, led_b;
  logic [15:0] addr_b, err_b;
  logic [7:0] dw_b;

  logic m_exec, m_rh, m_busy, m_rwd, m_pass, m_led;
  logic [15:0] m_addr, m_err;
  logic [7:0] m_dw;

  cmd_t cmd_q[$];
  res_t res_q[$];
  int checks = 0;
  int errors = 0;
  int results_seen = 0;
  int exec_seen = 0;
  int nack_left = 0;
  logic corrupt = 1'b0;
  logic [7:0] mem [256];

  always #5 clk = ~clk;

  assign done_a = done && !sel;
  assign done_b = done && sel;
  assign m_exec = sel ? exec_b : exec_a;
  assign m_rh   = sel ? rh_b   : rh_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_rwd  = sel ? rwd_b  : rwd_a;
  assign m_pass = sel ? pass_b : pass_a;
  assign m_led  = sel ? led_b  : led_a;
  assign m_addr = sel ? addr_b : addr_a;
  assign m_err  = sel ? err_b  : err_a;
  assign m_dw   = sel ? dw_b   : dw_a;

  e2prom_rw_seq #(
    .MAX_BYTE(16'd3), .START_ADDR(16'h0000), .BIT_CTRL(1'b1), .WR_WAIT(20'd20),
    .PATTERN(2'd0), .RETRY_MAX(3'd3), .L_TIME(25'd10)
  ) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start_a),
    .i2c_exec(exec_a), .i2c_rh_wl(rh_a), .i2c_addr(addr_a), .i2c_data_w(dw_a),
    .i2c_data_r(rdata), .i2c_done(done_a), .i2c_ack(ack),
    .busy(busy_a), .rw_done(rwd_a), .rw_pass(pass_a), .err_cnt(err_a), .led(led_a)
  );

  e2prom_rw_seq #(
    .MAX_BYTE(16'd4), .START_ADDR(16'h00FE), .BIT_CTRL(1'b0), .WR_WAIT(20'd4),
    .PATTERN(2'd2), .RETRY_MAX(3'd3), .L_TIME(25'd10)
  ) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start_b),
    .i2c_exec(exec_b), .i2c_rh_wl(rh_b), .i2c_addr(addr_b), .i2c_data_w(dw_b),
    .i2c_data_r(rdata), .i2c_done(done_b), .i2c_ack(ack),
    .busy(busy_b), .rw_done(rwd_b), .rw_pass(pass_b), .err_cnt(err_b), .led(led_b)
  );

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic pushCmd(input logic rh, input logic [15:0] addr, input logic [7:0] data);
    cmd_t c;
    c.rh = rh;
    c.addr = addr;
    c.data = data;
    cmd_q.push_back(c);
  endtask

  task automatic pushRes(input logic pass, input logic [15:0] err);
    res_t r;
    r.pass = pass;
    r.err = err;
    res_q.push_back(r);
  endtask

  // Ideal EEPROM with optional NACKs on writes to address 0 and a corrupted read at address 1
  initial begin
    logic       c_rh;
    logic [15:0] c_addr;
    logic [7:0] c_data;
    forever begin
      @(negedge clk);
      if (rst_n && m_exec) begin
        c_rh = m_rh;
        c_addr = m_addr;
        c_data = m_dw;
        repeat (3) @(posedge clk);
        #1;
        if (!c_rh && c_addr == 16'h0000 && nack_left > 0) begin
          ack = 1'b1;
          nack_left--;
        end else begin
          ack = 1'b0;
          if (!c_rh) mem[c_addr[7:0]] = c_data;
          else rdata = mem[c_addr[7:0]] ^ ((corrupt && c_addr == 16'h0001) ? 8'h01 : 8'h00);
        end
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        ack = 1'b0;
      end
    end
  end

  // Monitor: pops expected commands on each exec pulse and expected results on rw_done
  initial begin
    cmd_t e;
    res_t r;
    forever begin
      @(negedge clk);
      if (rst_n && m_exec) begin
        exec_seen++;
        if (cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_exec: got rh=%b addr=%h, required no command", m_rh, m_addr);
        end else begin
          e = cmd_q.pop_front();
          checkOutput("cmd", {39'd0, m_rh, m_addr, (e.rh ? 8'h00 : m_dw)},
                      {39'd0, e.rh, e.addr, (e.rh ? 8'h00 : e.data)});
        end
      end
      if (rst_n && m_rwd) begin
        if (res_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got pass=%b err=%0d, required no result", m_pass, m_err);
        end else begin
          r = res_q.pop_front();
          checkOutput("result_pass_err_busy", {46'd0, m_pass, m_err, m_busy}, {46'd0, r.pass, r.err, 1'b0});
          checkOutput("pending_cmds_at_done", 64'(cmd_q.size()), 64'd0);
        end
        results_seen++;
      end
    end
  end

  task automatic applyStimulus(input logic which, input int exp_execs);
    int before_res;
    int before_exec;
    int budget;
    before_res = results_seen;
    before_exec = exec_seen;
    sel = which;
    @(posedge clk);
    #1;
    if (which) start_b = 1'b1;
    else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    budget = 0;
    while (results_seen == before_res && budget < 3000) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (results_seen == before_res) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: no rw_done after %0d cycles, required rw_done", budget);
      cmd_q.delete();
      res_q.delete();
    end
    checkOutput("exec_count", 64'(exec_seen - before_exec), 64'(exp_execs));
  endtask

  task automatic pushPassRun();
    pushCmd(1'b0, 16'h0000, 8'h00);
    pushCmd(1'b0, 16'h0001, 8'h01);
    pushCmd(1'b0, 16'h0002, 8'h02);
    pushCmd(1'b1, 16'h0000, 8'h00);
    pushCmd(1'b1, 16'h0001, 8'h00);
    pushCmd(1'b1, 16'h0002, 8'h00);
    pushRes(1'b1, 16'h0000);
  endtask

  function automatic logic [63:0] outsA();
    return {18'd0, busy_a, rwd_a, pass_a, err_a, led_a, exec_a, rh_a, addr_a, dw_a};
  endfunction

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs_a", outsA(), 64'd0);
    checkOutput("reset_outputs_b",
                {18'd0, busy_b, rwd_b, pass_b, err_b, led_b, exec_b, rh_b, addr_b, dw_b}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    $display("[TB] PATTERN 0, 3 bytes, ideal EEPROM");
    pushPassRun();
    applyStimulus(1'b0, 6);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("led_pass_held", {62'd0, m_led, m_pass}, 64'h3);

    $display("[TB] 8-bit address wrap from FE with LFSR data");
    pushCmd(1'b0, 16'h00FE, 8'hA5);
    pushCmd(1'b0, 16'h00FF, 8'h4A);
    pushCmd(1'b0, 16'h0000, 8'h95);
    pushCmd(1'b0, 16'h0001, 8'h2A);
    pushCmd(1'b1, 16'h00FE, 8'h00);
    pushCmd(1'b1, 16'h00FF, 8'h00);
    pushCmd(1'b1, 16'h0000, 8'h00);
    pushCmd(1'b1, 16'h0001, 8'h00);
    pushRes(1'b1, 16'h0000);
    applyStimulus(1'b1, 8);

    $display("[TB] corrupted read at address 1");
    corrupt = 1'b1;
    pushCmd(1'b0, 16'h0000, 8'h00);
    pushCmd(1'b0, 16'h0001, 8'h01);
    pushCmd(1'b0, 16'h0002, 8'h02);
    pushCmd(1'b1, 16'h0000, 8'h00);
    pushCmd(1'b1, 16'h0001, 8'h00);
`ifdef E2PROM_RW_STOP_ON_ERR_EN
    pushRes(1'b0, 16'h0001);
    applyStimulus(1'b0, 5);
`else
    pushCmd(1'b1, 16'h0002, 8'h00);
    pushRes(1'b0, 16'h0001);
    applyStimulus(1'b0, 6);
`endif
    n = 0;
    while (!m_led && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    n = 0;
    while (m_led && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("led_blink_period", 64'(n), 64'd10);
    checkOutput("fail_pass_held", {63'd0, m_pass}, 64'd0);
    corrupt = 1'b0;

    $display("[TB] two NACKs on first write then success");
    nack_left = 2;
    pushCmd(1'b0, 16'h0000, 8'h00);
    pushCmd(1'b0, 16'h0000, 8'h00);
    pushPassRun();
    applyStimulus(1'b0, 8);

    $display("[TB] four NACKs on first write abort");
    nack_left = 4;
    repeat (4) pushCmd(1'b0, 16'h0000, 8'h00);
    pushRes(1'b0, 16'h0000);
    applyStimulus(1'b0, 4);
    nack_left = 0;

    $display("[TB] reset during write delay, then rerun");
    sel = 1'b0;
    pushCmd(1'b0, 16'h0000, 8'h00);
    @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("first_write_done_seen", {63'd0, done}, 64'd1);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("reset_mid_run_outputs", outsA(), 64'd0);
    checkOutput("pending_cmds_at_reset", 64'(cmd_q.size()), 64'd0);
    cmd_q.delete();
    res_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    pushPassRun();
    applyStimulus(1'b0, 6);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
